// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared opcodes, state encoding, ALU/select codes and trap causes
package riscv_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_EXEC_ADDR, S_EXEC_BRANCH,
    S_EXEC_LUI, S_MEM_RD, S_MEM_WR, S_WB_ALU, S_WB_MEM, S_TRAP
  } state_t;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [2:0] ALU_FUNC = 3'b000;
  localparam logic [2:0] ALU_CMP  = 3'b001;
  localparam logic [2:0] ALU_PASS = 3'b010;
  localparam logic [2:0] ALU_ADD  = 3'b011;
  localparam logic [1:0] SRC_A_PC   = 2'b00;
  localparam logic [1:0] SRC_A_RS1  = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  function automatic state_t dispatch(input logic [6:0] op);
    return op == OP_R ? S_EXEC_R :
           op == OP_I ? S_EXEC_I :
           (op == OP_LOAD || op == OP_STORE) ? S_EXEC_ADDR :
           op == OP_BRANCH ? S_EXEC_BRANCH :
           op == OP_LUI ? S_EXEC_LUI : S_TRAP;
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts unacknowledged memory request cycles and flags timeout
module mem_wait_timer #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic waiting,
  output logic expired
);
  localparam int W = $clog2(WAIT_LIMIT + 1);
  logic [W-1:0] cnt;
  // restart on every state change, otherwise count each waiting cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= clear ? '0 : waiting ? cnt + 1'b1 : cnt;
  assign expired = waiting && cnt == W'(WAIT_LIMIT - 1);
endmodule

// File: rtl/multi_cycle_control.sv
// multi_cycle_control: multi-cycle RISC-V control FSM with memory handshake and trap
module multi_cycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] OP_i,
  input  logic       Zero_i,
  input  logic       Mem_Ready_i,
  output logic       PC_Write_o,
  output logic       PC_Write_Cond_o,
  output logic       PC_Src_o,
  output logic       I_or_D_o,
  output logic       IR_Write_o,
  output logic       Mem_Read_o,
  output logic       Mem_Write_o,
  output logic       Mem_to_Reg_o,
  output logic       Reg_Write_o,
  output logic [1:0] ALU_Src_A_o,
  output logic [1:0] ALU_Src_B_o,
  output logic [2:0] ALU_Op_o,
  output logic       Retire_o,
  output logic       Trap_o,
  output logic [1:0] Trap_Cause_o
);
  state_t state, next_state;
  logic run, ack, waiting, expired;
  logic [1:0] cause;
  assign ack = run && Mem_Ready_i;
  assign waiting = run && !Mem_Ready_i &&
                   (state == S_FETCH || state == S_MEM_RD || state == S_MEM_WR);
  assign Trap_o = state == S_TRAP;
  assign Trap_Cause_o = cause;
  mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
    .clk(clk),
    .reset(reset),
    .clear(next_state != state),
    .waiting(waiting),
    .expired(expired)
  );
  // run holds strobes off until the first edge after reset is released
  always_ff @(posedge clk or posedge reset)
    if (reset) run <= 1'b0;
    else run <= 1'b1;
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_FETCH;
    else state <= next_state;
  // latch the reason on entry to TRAP and hold it until reset
  always_ff @(posedge clk or posedge reset)
    if (reset) cause <= CAUSE_NONE;
    else if (next_state == S_TRAP && state != S_TRAP)
      cause <= expired ? CAUSE_TIMEOUT : CAUSE_ILLEGAL;
  // next-state and output decode
  always_comb begin
    next_state = state;
    PC_Write_o = 1'b0;
    PC_Write_Cond_o = 1'b0;
    PC_Src_o = 1'b0;
    I_or_D_o = 1'b0;
    IR_Write_o = 1'b0;
    Mem_Read_o = 1'b0;
    Mem_Write_o = 1'b0;
    Mem_to_Reg_o = 1'b0;
    Reg_Write_o = 1'b0;
    ALU_Src_A_o = SRC_A_PC;
    ALU_Src_B_o = SRC_B_RS2;
    ALU_Op_o = ALU_FUNC;
    Retire_o = 1'b0;
    case (state)
      S_FETCH: begin
        Mem_Read_o = 1'b1;
        ALU_Src_B_o = SRC_B_FOUR;
        ALU_Op_o = ALU_ADD;
        IR_Write_o = ack;
        PC_Write_o = ack;
        next_state = ack ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALU_Src_B_o = SRC_B_IMM;
        ALU_Op_o = ALU_ADD;
        next_state = dispatch(OP_i);
      end
      S_EXEC_R: begin
        ALU_Src_A_o = SRC_A_RS1;
        next_state = S_WB_ALU;
      end
      S_EXEC_I: begin
        ALU_Src_A_o = SRC_A_RS1;
        ALU_Src_B_o = SRC_B_IMM;
        next_state = S_WB_ALU;
      end
      S_EXEC_LUI: begin
        ALU_Src_A_o = SRC_A_ZERO;
        ALU_Src_B_o = SRC_B_IMM;
        ALU_Op_o = ALU_PASS;
        next_state = S_WB_ALU;
      end
      S_EXEC_ADDR: begin
        ALU_Src_A_o = SRC_A_RS1;
        ALU_Src_B_o = SRC_B_IMM;
        ALU_Op_o = ALU_ADD;
        next_state = OP_i == OP_LOAD ? S_MEM_RD : S_MEM_WR;
      end
      S_EXEC_BRANCH: begin
        ALU_Src_A_o = SRC_A_RS1;
        ALU_Op_o = ALU_CMP;
        PC_Write_Cond_o = 1'b1;
        PC_Src_o = 1'b1;
        Retire_o = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_RD: begin
        Mem_Read_o = 1'b1;
        I_or_D_o = 1'b1;
        next_state = ack ? S_WB_MEM : S_MEM_RD;
      end
      S_MEM_WR: begin
        Mem_Write_o = 1'b1;
        I_or_D_o = 1'b1;
        Retire_o = ack;
        next_state = ack ? S_FETCH : S_MEM_WR;
      end
      S_WB_ALU: begin
        Reg_Write_o = 1'b1;
        Retire_o = 1'b1;
        next_state = S_FETCH;
      end
      S_WB_MEM: begin
        Reg_Write_o = 1'b1;
        Mem_to_Reg_o = 1'b1;
        Retire_o = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_TRAP;
    endcase
    if (expired) next_state = S_TRAP;
    if (!run) begin
      {PC_Write_o, PC_Write_Cond_o, IR_Write_o, Mem_Read_o, Mem_Write_o} = '0;
      {Reg_Write_o, Retire_o} = '0;
    end
  end
endmodule

// File: tb/tb_multi_cycle_control.sv
// tb_multi_cycle_control: table, random and corner-case checks against a cycle-list model
module tb_multi_cycle_control;
  logic clk = 1'b0, reset = 1'b0, zero = 1'b0, rdy = 1'b0;
  logic [6:0] op = 7'b0;
  logic pcw, pcwc, pcs, iord, irw, mr, mw, m2r, rw, ret, trap;
  logic [1:0] sa, sb, cause;
  logic [2:0] aop;
  int tests = 0, failed = 0;
  always #5 clk = ~clk;
  multi_cycle_control #(.WAIT_LIMIT(16)) dut (
    .clk(clk), .reset(reset), .OP_i(op), .Zero_i(zero), .Mem_Ready_i(rdy),
    .PC_Write_o(pcw), .PC_Write_Cond_o(pcwc), .PC_Src_o(pcs), .I_or_D_o(iord),
    .IR_Write_o(irw), .Mem_Read_o(mr), .Mem_Write_o(mw), .Mem_to_Reg_o(m2r),
    .Reg_Write_o(rw), .ALU_Src_A_o(sa), .ALU_Src_B_o(sb), .ALU_Op_o(aop),
    .Retire_o(ret), .Trap_o(trap), .Trap_Cause_o(cause)
  );
  wire [19:0] act = {pcw, pcwc, pcs, iord, irw, mr, mw, m2r, rw, sa, sb, aop, ret, trap, cause};
  localparam logic [19:0] PCW = 20'h80000, PCWC = 20'h40000, PCS = 20'h20000, IORD = 20'h10000;
  localparam logic [19:0] IRW = 20'h08000, MR = 20'h04000, MW = 20'h02000, M2R = 20'h01000;
  localparam logic [19:0] RW = 20'h00800, RET = 20'h00008, TRAP = 20'h00004;
  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011, BR = 7'b1100011, LUI = 7'b0110111;
  typedef struct {logic dc; logic rdy; logic [19:0] vec;} step_t;
  typedef struct {logic [6:0] op; int fw; int mw; logic z; int lat;} vec_t;
  step_t q[$];
  vec_t tbl[11];
  logic [6:0] legal[6] = '{R, I, LD, ST, BR, LUI};
  int lat;
  function automatic logic [19:0] alu(input logic [1:0] a, input logic [1:0] b, input logic [2:0] o);
    return {9'b0, a, b, o, 4'b0};
  endfunction
  task automatic push(input logic dc, input logic r, input logic [19:0] v);
    q.push_back('{dc, r, v});
  endtask
  task automatic check(input string name, input logic [19:0] got, input logic [19:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s at %0t: outputs=%h required=%h", name, $time, got, exp);
    end
  endtask
  task automatic check_int(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      failed++;
      $display("FAIL %s at %0t: value=%0d required=%0d", name, $time, got, exp);
    end
  endtask
  task automatic fetch(input int fw);
    for (int k = 0; k < fw; k++) push(0, 0, MR | alu(0, 1, 3));
    push(0, 1, MR | IRW | PCW | alu(0, 1, 3));
    push(1, 0, alu(0, 2, 3));
  endtask
  // expected per-cycle output list for one instruction, straight from the opcode rules
  task automatic build(input logic [6:0] o, input int fw, input int mwt);
    op = o;
    fetch(fw);
    case (o)
      R:   begin push(1, 0, alu(1, 0, 0)); push(1, 0, RW | RET); end
      I:   begin push(1, 0, alu(1, 2, 0)); push(1, 0, RW | RET); end
      LUI: begin push(1, 0, alu(2, 2, 2)); push(1, 0, RW | RET); end
      BR:  push(1, 0, PCWC | PCS | RET | alu(1, 0, 1));
      LD: begin
        push(1, 0, alu(1, 2, 3));
        for (int k = 0; k < mwt; k++) push(0, 0, MR | IORD);
        push(0, 1, MR | IORD);
        push(1, 0, RW | M2R | RET);
      end
      ST: begin
        push(1, 0, alu(1, 2, 3));
        for (int k = 0; k < mwt; k++) push(0, 0, MW | IORD);
        push(0, 1, MW | IORD | RET);
      end
      default: for (int k = 0; k < 3; k++) push(1, 0, TRAP | 20'h1);
    endcase
  endtask
  function automatic int latency(input logic [6:0] o, input int fw, input int mwt);
    return fw + (o == BR ? 3 : o == LD ? 5 + mwt : o == ST ? 4 + mwt : 4);
  endfunction
  task automatic play(input string name, input logic z, output int l);
    l = 0;
    for (int k = 0; k < q.size(); k++) begin
      @(posedge clk);
      #1 rdy = q[k].dc ? 1'($urandom_range(0, 1)) : q[k].rdy;
      zero = z;
      @(negedge clk);
      check(name, act, q[k].vec);
      if (act[3] && l == 0) l = k + 1;
    end
    q.delete();
  endtask
  task automatic do_reset(input string name);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check(name, act, alu(0, 1, 3));
    @(negedge clk);
    check(name, act, alu(0, 1, 3));
    reset = 1'b0;
    #1 check(name, act, alu(0, 1, 3));
  endtask
  initial begin
    tbl[0]  = '{R,  0, 0,  1'b0, 4};
    tbl[1]  = '{I,  2, 0,  1'b0, 6};
    tbl[2]  = '{LUI, 0, 0, 1'b0, 4};
    tbl[3]  = '{LD, 0, 3,  1'b0, 8};
    tbl[4]  = '{LD, 0, 0,  1'b0, 5};
    tbl[5]  = '{ST, 0, 0,  1'b0, 4};
    tbl[6]  = '{ST, 1, 2,  1'b0, 7};
    tbl[7]  = '{BR, 0, 0,  1'b1, 3};
    tbl[8]  = '{BR, 0, 0,  1'b0, 3};
    tbl[9]  = '{LD, 10, 10, 1'b0, 25};
    tbl[10] = '{ST, 15, 15, 1'b1, 34};
    do_reset("reset");
    foreach (tbl[n]) begin
      build(tbl[n].op, tbl[n].fw, tbl[n].mw);
      play("table", tbl[n].z, lat);
      check_int("table_latency", lat, tbl[n].lat);
    end
    for (int n = 0; n < 40; n++) begin
      logic [6:0] o;
      int fw, mwt;
      o = legal[$urandom_range(0, 5)];
      fw = $urandom_range(0, 5);
      mwt = $urandom_range(0, 5);
      build(o, fw, mwt);
      play("random", 1'($urandom_range(0, 1)), lat);
      check_int("random_latency", lat, latency(o, fw, o == LD || o == ST ? mwt : 0));
    end
    build(7'b1111111, 0, 0);
    play("illegal_trap", 1'b0, lat);
    do_reset("reset_after_illegal");
    op = ST;
    fetch(0);
    push(1, 0, alu(1, 2, 3));
    for (int k = 0; k < 16; k++) push(0, 0, MW | IORD);
    for (int k = 0; k < 3; k++) push(1, 0, TRAP | 20'h2);
    play("timeout_trap", 1'b0, lat);
    do_reset("reset_after_timeout");
    op = LD;
    fetch(0);
    push(1, 0, alu(1, 2, 3));
    for (int k = 0; k < 3; k++) push(0, 0, MR | IORD);
    play("pre_reset_load", 1'b0, lat);
    do_reset("reset_mid_mem_rd");
    build(R, 0, 0);
    play("after_mid_reset", 1'b0, lat);
    check_int("after_mid_reset_latency", lat, 4);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
